// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
//
// Host-side bundle of the shift-register transaction sequencer.
//   master : the requester (drives start/mode/din/sin and, when built with
//            SHIFT_SEQ_ABORT_EN, abort)
//   slave  : the sequencer (drives busy/done/ser_out/ser_valid/sin_rdy/dout)
//
// Signals
//   start     request a transfer (sampled only while idle)
//   mode      0 PISO MSB-first, 1 PISO LSB-first,
//             2 SIPO first-bit-to-MSB, 3 SIPO first-bit-to-LSB
//   din       parallel word for PISO, latched on accept
//   sin       serial input bit for SIPO
//   abort     (SHIFT_SEQ_ABORT_EN only) cancel the running transfer
//   busy      transfer in progress
//   done      one-cycle completion pulse
//   ser_out   serial PISO bit
//   ser_valid ser_out qualifier
//   sin_rdy   sin is consumed this cycle
//   dout      captured SIPO word
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if #(
    parameter int DW = 4
);
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] din;
    logic          sin;
    logic          busy;
    logic          done;
    logic          ser_out;
    logic          ser_valid;
    logic          sin_rdy;
    logic [DW-1:0] dout;

`ifdef SHIFT_SEQ_ABORT_EN
    logic          abort;

    modport master (
        output start, mode, din, sin, abort,
        input  busy, done, ser_out, ser_valid, sin_rdy, dout
    );

    modport slave (
        input  start, mode, din, sin, abort,
        output busy, done, ser_out, ser_valid, sin_rdy, dout
    );
`else
    modport master (
        output start, mode, din, sin,
        input  busy, done, ser_out, ser_valid, sin_rdy, dout
    );

    modport slave (
        input  start, mode, din, sin,
        output busy, done, ser_out, ser_valid, sin_rdy, dout
    );
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Transaction sequencer for the universal shift register. A start request
// with a mode and a parallel word is turned into the exact enable / load-shift
// / mode-select sequence the register needs for one serialize (PISO) or
// deserialize (SIPO) transfer. The serial stream is qualified, the SIPO word
// is captured from the register's registered output, and completion is
// reported with a one-cycle done pulse.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add host.abort, which
// returns any running transfer to IDLE on the next edge without a done pulse.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   host       shift_seq_ctrl_if.slave (start/mode/din/sin[/abort] in,
//              busy/done/ser_out/ser_valid/sin_rdy/dout out)
//   reg_enb    register enable
//   reg_l_s    register load (1) / shift (0)
//   reg_switch register mode select (mode+1 while busy, 0 when idle)
//   reg_inp    register parallel/serial input
//   reg_out    register registered output
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_ctrl_if.slave host,
    output logic            reg_enb,
    output logic            reg_l_s,
    output logic [2:0]      reg_switch,
    output logic [DW-1:0]   reg_inp,
    input  logic [DW-1:0]   reg_out
);
    localparam int CNT_W = $clog2(DW + 2);

    // Last counter value in SHIFT: PISO runs DW cycles, SIPO runs DW+1
    // (the extra one is the flush edge that moves the word into reg_out).
    localparam logic [CNT_W-1:0] CNT_LAST_PISO = CNT_W'(DW - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_SIPO = CNT_W'(DW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       mode_reg;
    logic [DW-1:0]    din_reg;
    logic [DW-1:0]    dout_reg;

    logic accept;
    logic capt_en;
    logic abort_hit;
    logic is_sipo;
    logic done_int;
    logic ser_valid_int;
    logic sin_rdy_int;

    assign is_sipo = mode_reg[1];
    assign accept  = (state_reg == IDLE) && host.start;

`ifdef SHIFT_SEQ_ABORT_EN
    // abort is meaningless while idle, so a simultaneous start still wins.
    assign abort_hit = host.abort && (state_reg != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, counter, latched request and captured word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= '0;
            din_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                mode_reg <= host.mode;
                din_reg  <= host.din;
            end
            if (capt_en) begin
                dout_reg <= reg_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and register-side controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        capt_en       = 1'b0;
        done_int      = 1'b0;
        ser_valid_int = 1'b0;
        sin_rdy_int   = 1'b0;
        reg_enb       = 1'b0;
        reg_l_s       = 1'b0;
        reg_inp       = '0;
        reg_switch    = 3'd0;

        // Mode select stays put for the whole transfer, from accept to DONE.
        if (state_reg != IDLE) begin
            reg_switch = {1'b0, mode_reg} + 3'd1;
        end

        unique case (state_reg)
            IDLE: begin
                if (host.start) begin
                    state_next = host.mode[1] ? SHIFT : LOAD;
                end
            end
            LOAD: begin
                reg_enb    = 1'b1;
                reg_l_s    = 1'b1;
                reg_inp    = din_reg;
                state_next = SHIFT;
            end
            SHIFT: begin
                reg_enb = 1'b1;
                if (!is_sipo) begin
                    // reg_out lags the register contents by one enabled
                    // edge, so the first valid bit appears at counter 1.
                    ser_valid_int = (cnt_reg != '0);
                    if (cnt_reg == CNT_LAST_PISO) begin
                        state_next = TAIL;
                    end
                end else if (cnt_reg != CNT_LAST_SIPO) begin
                    reg_inp     = {{(DW-1){1'b0}}, host.sin};
                    sin_rdy_int = 1'b1;
                end else begin
                    // Flush edge: shifts in a dummy 0 but copies the
                    // complete word into reg_out.
                    state_next = CAPT;
                end
            end
            TAIL: begin
                // Register is frozen; reg_out still holds the last bit.
                ser_valid_int = 1'b1;
                state_next    = DONE;
            end
            CAPT: begin
                capt_en    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_int   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_hit) begin
            state_next = IDLE;
            capt_en    = 1'b0;
            done_int   = 1'b0;
        end
    end

    // Counter restarts on every state change and only advances in SHIFT,
    // where it is bounded by the exit conditions above.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (state_reg == SHIFT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign host.busy      = (state_reg != IDLE);
    assign host.done      = done_int;
    assign host.ser_out   = reg_out[0];
    assign host.ser_valid = ser_valid_int;
    assign host.sin_rdy   = sin_rdy_int;
    assign host.dout      = dout_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Closed-loop bench: a behavioural universal shift register is wired to the
// sequencer's register-side ports. Stimulus pushes expected serial bits and
// expected completion words into queues; an independent monitor pops and
// compares whenever ser_valid or done is presented.
//
// Register model (switch codes):
//   every enabled edge copies the pre-edge contents to out
//   load : switch 1 stores the word bit-reversed (so out[0] yields MSB first),
//          other switches store it as is
//   1,2  : shift right
//   3    : shift left, inp[0] enters at bit 0   (first bit ends at MSB)
//   4    : shift right, inp[0] enters at MSB    (first bit ends at LSB)
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.DW(DW)) host_if ();

    logic          reg_enb;
    logic          reg_l_s;
    logic [2:0]    reg_switch;
    logic [DW-1:0] reg_inp;
    logic [DW-1:0] reg_out;

    shift_seq_ctrl #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if),
        .reg_enb    (reg_enb),
        .reg_l_s    (reg_l_s),
        .reg_switch (reg_switch),
        .reg_inp    (reg_inp),
        .reg_out    (reg_out)
    );

    // ------------------------------------------------------------------
    // Behavioural shift register
    // ------------------------------------------------------------------
    logic [DW-1:0] ur_r;

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ur_r    <= '0;
            reg_out <= '0;
        end else if (reg_enb) begin
            reg_out <= ur_r;
            if (reg_l_s) begin
                ur_r <= (reg_switch == 3'd1) ? rev(reg_inp) : reg_inp;
            end else begin
                case (reg_switch)
                    3'd1, 3'd2: ur_r <= ur_r >> 1;
                    3'd3:       ur_r <= {ur_r[DW-2:0], reg_inp[0]};
                    3'd4:       ur_r <= {reg_inp[0], ur_r[DW-1:1]};
                    default:    ur_r <= ur_r;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int            checks = 0;
    int            errors = 0;
    bit            exp_ser[$];
    logic [DW-1:0] exp_dout[$];
    bit            sin_src[$];
    int            sin_seen;
    int            load_seen;
    int            done_seen;
    logic          sw_bad;
    logic [2:0]    exp_sw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares serial bits and completion words as they appear.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (host_if.ser_valid) begin
                checks++;
                if (exp_ser.size() == 0) begin
                    errors++;
                    $display("FAIL ser_unexpected: got ser_valid with ser_out=%b, expected none", host_if.ser_out);
                end else begin
                    checks--;
                    check("ser_out", 32'(host_if.ser_out), 32'(exp_ser.pop_front()));
                end
            end
            if (host_if.done) begin
                checks++;
                if (exp_dout.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done with dout=%b, expected none", host_if.dout);
                end else begin
                    checks--;
                    check("dout", 32'(host_if.dout), 32'(exp_dout.pop_front()));
                    $display("xfer complete: dout=%b", host_if.dout);
                end
            end
        end
    end

    // Serial source: presents the next SIPO bit whenever the DUT will consume.
    initial forever begin
        @(negedge clk);
        if (host_if.sin_rdy && sin_src.size() > 0) host_if.sin = sin_src.pop_front();
    end

    // Per-transfer observation counters.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (host_if.sin_rdy)        sin_seen++;
            if (reg_enb && reg_l_s)     load_seen++;
            if (host_if.done)           done_seen++;
            if (host_if.busy && reg_switch !== exp_sw) sw_bad = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (host_if.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(host_if.busy), 0);
    endtask

    // Called at the negedge of cycle 1 after accept.
    task automatic finish_xfer(input logic [1:0] m);
        int lat = 1;
        while (!host_if.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(DW + 3));
        @(negedge clk);
        check("busy_after_done", 32'(host_if.busy), 0);
        check("load_cycles", 32'(load_seen), m[1] ? 0 : 1);
        check("sin_rdy_cycles", 32'(sin_seen), m[1] ? 32'(DW) : 0);
        check("reg_switch_hold", 32'(sw_bad), 0);
    endtask

    task automatic issue(input logic [1:0] m, input logic [DW-1:0] d);
        wait_idle();
        host_if.start = 1'b1;
        host_if.mode  = m;
        host_if.din   = d;
        exp_sw        = {1'b0, m} + 3'd1;
        sin_seen      = 0;
        load_seen     = 0;
        sw_bad        = 1'b0;
        @(negedge clk);
`ifdef SHIFT_SEQ_ABORT_EN
        host_if.abort = 1'b0;
`endif
    endtask

    // Full transfer; with hold=1 start stays high and mode/din are scrambled
    // after accept, which must not disturb the running transfer.
    task automatic run_xfer(input logic [1:0] m, input logic [DW-1:0] d, input bit hold);
        issue(m, d);
        if (!hold) host_if.start = 1'b0;
        host_if.mode = ~m;
        host_if.din  = ~d;
        finish_xfer(m);
    endtask

    task automatic push_ser(input logic [DW-1:0] bits_first_at_msb);
        logic [DW-1:0] b;
        b = bits_first_at_msb;
        for (int i = DW - 1; i >= 0; i--) exp_ser.push_back(b[i]);
    endtask

    task automatic push_sin(input logic [DW-1:0] bits_first_at_msb);
        logic [DW-1:0] b;
        b = bits_first_at_msb;
        for (int i = DW - 1; i >= 0; i--) sin_src.push_back(b[i]);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        host_if.start = 1'b0;
        host_if.mode  = 2'd0;
        host_if.din   = '0;
        host_if.sin   = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        host_if.abort = 1'b0;
`endif
        exp_sw = 3'd0;
        sw_bad = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",       32'(host_if.busy), 0);
        check("rst_done",       32'(host_if.done), 0);
        check("rst_ser_valid",  32'(host_if.ser_valid), 0);
        check("rst_sin_rdy",    32'(host_if.sin_rdy), 0);
        check("rst_dout",       32'(host_if.dout), 0);
        check("rst_reg_enb",    32'(reg_enb), 0);
        check("rst_reg_l_s",    32'(reg_l_s), 0);
        check("rst_reg_switch", 32'(reg_switch), 0);
        check("rst_reg_inp",    32'(reg_inp), 0);
        rst = 1'b1;

        // PISO MSB-first, din=1011 -> 1,0,1,1
        push_ser(4'b1011);
        exp_dout.push_back(4'b0000);
        run_xfer(2'd0, 4'b1011, 1'b0);

        // PISO LSB-first, din=1011 -> 1,1,0,1
        push_ser(4'b1101);
        exp_dout.push_back(4'b0000);
        run_xfer(2'd1, 4'b1011, 1'b0);

        // SIPO first-bit-to-MSB, sin 1,1,0,1 -> 1101
        push_sin(4'b1101);
        exp_dout.push_back(4'b1101);
        run_xfer(2'd2, 4'b0000, 1'b0);

        // SIPO first-bit-to-LSB, sin 1,1,0,1 -> 1011
        push_sin(4'b1101);
        exp_dout.push_back(4'b1011);
        run_xfer(2'd3, 4'b0000, 1'b0);

        // start held high through a PISO transfer; the follow-on request
        // (mode 3 after scrambling) is accepted on the first IDLE cycle.
        push_ser(4'b0110);
        exp_dout.push_back(4'b1011);
        push_sin(4'b0111);
        exp_dout.push_back(4'b1110);
        run_xfer(2'd0, 4'b0110, 1'b1);
        exp_sw    = 3'd4;
        sin_seen  = 0;
        load_seen = 0;
        sw_bad    = 1'b0;
        @(negedge clk);
        host_if.start = 1'b0;
        check("accept_first_idle", 32'(host_if.busy), 1);
        finish_xfer(2'd3);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort mid-SHIFT: back to IDLE, no done, dout keeps 1110.
        push_sin(4'b1001);
        issue(2'd2, 4'b0000);
        host_if.start = 1'b0;
        @(negedge clk);
        host_if.abort = 1'b1;
        @(negedge clk);
        host_if.abort = 1'b0;
        check("abort_busy",    32'(host_if.busy), 0);
        check("abort_reg_enb", 32'(reg_enb), 0);
        check("abort_sin_rdy", 32'(host_if.sin_rdy), 0);
        done_seen = 0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_dout",    32'(host_if.dout), 32'(4'b1110));
        sin_src.delete();

        // abort together with start in IDLE: start wins.
        push_ser(4'b0001);
        exp_dout.push_back(4'b1110);
        host_if.abort = 1'b1;
        run_xfer(2'd1, 4'b1000, 1'b0);
`endif

        // Reset asserted mid-SIPO: everything returns to reset values.
        push_sin(4'b1010);
        issue(2'd2, 4'b0000);
        host_if.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy",       32'(host_if.busy), 0);
        check("midrst_done",       32'(host_if.done), 0);
        check("midrst_sin_rdy",    32'(host_if.sin_rdy), 0);
        check("midrst_ser_valid",  32'(host_if.ser_valid), 0);
        check("midrst_dout",       32'(host_if.dout), 0);
        check("midrst_reg_enb",    32'(reg_enb), 0);
        check("midrst_reg_switch", 32'(reg_switch), 0);
        check("midrst_reg_inp",    32'(reg_inp), 0);
        sin_src.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Normal operation after reset: PISO LSB-first 0101 -> 1,0,1,0
        push_ser(4'b1010);
        exp_dout.push_back(4'b0000);
        run_xfer(2'd1, 4'b0101, 1'b0);

        repeat (3) @(negedge clk);
        check("ser_queue_drained",  32'(exp_ser.size()), 0);
        check("dout_queue_drained", 32'(exp_dout.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
